// File: rtl/midi_encoder.sv
`default_nettype none
// ============================================================================
// Module   : midi_encoder
// Purpose  : MIDI OUT event encoder. Accepts note/ctrl/prog/pitch/sysex
//            events over valid/ready, builds the MIDI frame and sends it
//            8N1, LSB first, one bit per CLK_DIV clocks.
// Options  : `define MIDI_ENC_RUNNING_STATUS_EN drops a channel status byte
//            when it repeats the last status sent.
// Revision : 1.0 - initial release
// ============================================================================
module midi_encoder #(
   parameter int         CLK_DIV = 800,
   parameter logic [7:0] SYX_ID  = 8'h7d,
   parameter logic [7:0] SYX_DEV = 8'h00
) (
   input  logic       CLOCK_25,
   input  logic       iRST,
   input  logic [3:0] midi_ch,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [2:0] ev_type,
   input  logic [7:0] ev_d1,
   input  logic [7:0] ev_d2,
   input  logic [7:0] ev_d3,
   output logic       midi_txd,
   output logic       byte_sent,
   output logic       frame_done
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_LOAD  = 3'd1;
   localparam logic [2:0] c_START = 3'd2;
   localparam logic [2:0] c_DATA  = 3'd3;
   localparam logic [2:0] c_STOP  = 3'd4;
   localparam logic [2:0] c_DONE  = 3'd5;

   localparam int            c_BW        = $clog2(CLK_DIV);
   localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLK_DIV - 1);
   localparam logic [c_BW-1:0] c_BAUD_ONE  = c_BW'(1);

   logic [2:0]      r_state;
   logic [2:0]      w_state_nxt;
   logic [c_BW-1:0] r_baud;
   logic [2:0]      r_bit;
   logic [2:0]      r_idx;
   logic [2:0]      r_last;
   logic [7:0]      r_shift;
   logic [2:0]      r_type;
   logic [3:0]      r_ch;
   logic [6:0]      r_d1;
   logic [6:0]      r_d2;
   logic [6:0]      r_d3;
   logic            w_accept;
   logic            w_baud_end;
   logic            w_reserved;
   logic            w_skip;
   logic [2:0]      w_last;
   logic [7:0]      w_byte;
   logic            w_unused_msb;

   // Status byte of a channel message (types 0-4)
   function automatic logic [7:0] f_status(input logic [2:0] t, input logic [3:0] ch);
      case (t)
         3'd0:    f_status = {4'h8, ch};
         3'd1:    f_status = {4'h9, ch};
         3'd2:    f_status = {4'hB, ch};
         3'd3:    f_status = {4'hC, ch};
         default: f_status = {4'hE, ch};
      endcase
   endfunction

   assign w_accept     = ev_valid & ev_ready;
   assign w_baud_end   = (r_baud == c_BAUD_LAST);
   assign w_reserved   = r_type[2] & r_type[1];
   assign w_unused_msb = ^{ev_d1[7], ev_d2[7], ev_d3[7]};

`ifdef MIDI_ENC_RUNNING_STATUS_EN
   logic [7:0] r_rs;
   logic       r_rs_vld;

   // Last status sent; sysex and reserved events invalidate it
   always_ff @(posedge CLOCK_25) begin
      if (iRST) begin
         r_rs     <= 8'h00;
         r_rs_vld <= 1'b0;
      end else if (w_accept) begin
         if (ev_type < 3'd5) begin
            r_rs     <= f_status(ev_type, midi_ch);
            r_rs_vld <= 1'b1;
         end else begin
            r_rs_vld <= 1'b0;
         end
      end
   end

   assign w_skip = r_rs_vld && (ev_type < 3'd5) && (r_rs == f_status(ev_type, midi_ch));
`else
   assign w_skip = 1'b0;
`endif

   // Index of the final byte for the event being accepted
   always_comb begin
      w_last = 3'd2;
      case (ev_type)
         3'd3:       w_last = 3'd1;
         3'd5:       w_last = 3'd6;
         3'd6, 3'd7: w_last = 3'd0;
         default:    w_last = 3'd2;
      endcase
   end

   // Byte selected by the frame index; data bytes carry bit7 = 0
   always_comb begin
      w_byte = 8'hFF;
      if (r_type == 3'd5) begin
         case (r_idx)
            3'd0:    w_byte = 8'hF0;
            3'd1:    w_byte = SYX_ID;
            3'd2:    w_byte = SYX_DEV;
            3'd3:    w_byte = {5'b0, r_d1[2:0]};
            3'd4:    w_byte = {1'b0, r_d2};
            3'd5:    w_byte = {1'b0, r_d3};
            default: w_byte = 8'hF7;
         endcase
      end else begin
         case (r_idx)
            3'd0:    w_byte = f_status(r_type, r_ch);
            3'd1:    w_byte = {1'b0, r_d1};
            default: w_byte = {1'b0, r_d2};
         endcase
      end
   end

   // State register
   always_ff @(posedge CLOCK_25) begin
      if (iRST) r_state <= c_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_state_nxt = c_LOAD;
         c_LOAD:  w_state_nxt = w_reserved ? c_DONE : c_START;
         c_START: if (w_baud_end) w_state_nxt = c_DATA;
         c_DATA:  if (w_baud_end && (r_bit == 3'd7)) w_state_nxt = c_STOP;
         c_STOP:  if (w_baud_end) w_state_nxt = (r_idx == r_last) ? c_DONE : c_LOAD;
         c_DONE:  w_state_nxt = w_accept ? c_LOAD : c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Output decode from state and shift register
   always_comb begin
      ev_ready   = (r_state == c_IDLE) || (r_state == c_DONE);
      midi_txd   = 1'b1;
      byte_sent  = (r_state == c_STOP) && w_baud_end;
      frame_done = (r_state == c_DONE);
      if (r_state == c_START)     midi_txd = 1'b0;
      else if (r_state == c_DATA) midi_txd = r_shift[0];
   end

   // Event latch, baud/bit/byte counters and shift register
   always_ff @(posedge CLOCK_25) begin
      if (iRST) begin
         r_baud  <= '0;
         r_bit   <= 3'd0;
         r_idx   <= 3'd0;
         r_last  <= 3'd0;
         r_shift <= 8'hFF;
         r_type  <= 3'd0;
         r_ch    <= 4'd0;
         r_d1    <= 7'd0;
         r_d2    <= 7'd0;
         r_d3    <= 7'd0;
      end else begin
         case (r_state)
            c_IDLE, c_DONE: begin
               if (w_accept) begin
                  r_type <= ev_type;
                  r_ch   <= midi_ch;
                  r_d1   <= ev_d1[6:0];
                  r_d2   <= ev_d2[6:0];
                  r_d3   <= ev_d3[6:0];
                  r_last <= w_last;
                  r_idx  <= w_skip ? 3'd1 : 3'd0;
               end
            end
            c_LOAD: begin
               r_shift <= w_byte;
               r_baud  <= '0;
               r_bit   <= 3'd0;
            end
            c_START: begin
               r_baud <= w_baud_end ? '0 : r_baud + c_BAUD_ONE;
            end
            c_DATA: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_bit   <= r_bit + 3'd1;
                  r_shift <= {1'b1, r_shift[7:1]};
               end else begin
                  r_baud <= r_baud + c_BAUD_ONE;
               end
            end
            c_STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  r_idx  <= r_idx + 3'd1;
               end else begin
                  r_baud <= r_baud + c_BAUD_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/midi_encoder.md
Name: midi_encoder

Overview:
- Transmit-side counterpart of the synth's MIDI input path.
- Accepts note, controller, program-change, pitch-bend and sysex parameter-write events from the panel/sequencer logic over a valid/ready handshake.
- Builds the corresponding MIDI message and serialises it 8N1 at 31250 baud on a MIDI OUT/THRU line.
- Sysex frames use the same layout the synth's own decoder consumes, so one board can program another.

Parameters:
- CLK_DIV, 800: CLOCK_25 cycles per bit; 25 MHz / 31250. Minimum 4.
- SYX_ID, 8'h7d: manufacturer byte, byte 1 of the sysex frame.
- SYX_DEV, 8'h00: device byte, byte 2 of the sysex frame.

Ports:
- CLOCK_25  in  1  system clock, all logic on the rising edge.
- iRST  in  1  reset, synchronous, active-high.
- midi_ch  in  4  channel nibble for channel messages; sampled on accept.
- ev_valid  in  1  event request.
- ev_ready  out  1  encoder idle; event accepted on the edge where ev_valid and ev_ready are both high.
- ev_type  in  3  event type: 0 note off, 1 note on, 2 ctrl, 3 prog, 4 pitch, 5 sysex, 6-7 reserved.
- ev_d1  in  8  key / ctrl / prog / pitch LSB / sysex bank.
- ev_d2  in  8  velocity / ctrl value / pitch MSB / sysex adr.
- ev_d3  in  8  sysex data; unused otherwise.
- midi_txd  out  1  serial output, idles high.
- byte_sent  out  1  one-cycle pulse at the end of each stop bit.
- frame_done  out  1  one-cycle pulse at the end of the last stop bit of a frame.

Behaviour:
- Reset: applies the cycle after iRST is sampled high, including mid-frame. midi_txd=1, ev_ready=1, byte_sent=0, frame_done=0, FSM=IDLE, bit and baud counters=0, running status cleared. Any partial byte is abandoned.
- Accept: all inputs are latched. ev_ready drops the next cycle and stays low until frame end.
- Data bytes: every data byte has bit7 forced to 0.
- Frames:
  - type 0: 8n,k,v
  - type 1: 9n,k,v
  - type 2: Bn,c,v
  - type 3: Cn,p (2 bytes)
  - type 4: En,lsb,msb
  - type 5: F0,SYX_ID,SYX_DEV,{5'b0,d1[2:0]},{1'b0,d2[6:0]},{1'b0,d3[6:0]},F7 (7 bytes)
  - n = latched midi_ch.
- Reserved types (6, 7): accepted, nothing transmitted, frame_done pulses 2 cycles after the accept edge, ev_ready high the same cycle.
- FSM states: IDLE -> LOAD -> START -> DATA -> STOP -> (LOAD if bytes remain, else DONE) -> IDLE.
  - LOAD is one cycle; it selects the byte by index.
  - START drives midi_txd low from the second rising edge after accept.
  - DATA shifts 8 bits LSB first.
  - STOP drives high.
  - Each of START, each DATA bit, and STOP lasts exactly CLK_DIV cycles.
- Inter-byte gap: exactly one LOAD cycle between bytes; midi_txd stays high during it.
- Byte index wraps only at frame end; the index counter is 3 bits.
- byte_sent pulses on the last cycle of each STOP.
- frame_done pulses in DONE. ev_ready is high in the same cycle, so a new event can be accepted one cycle after frame_done.
- ev_valid held with ev_ready low: no effect; no queueing.
- Input changes while busy: ignored; latched copies are used.

Optional Feature:
- Macro: MIDI_ENC_RUNNING_STATUS_EN.
- Defined:
  - A channel-message status byte is omitted when it equals the last transmitted status.
  - Sysex, reserved-type events and reset clear the running status, so the next channel message always sends status.
  - A note-on after a note-on with identical status sends 2 bytes.
- Undefined: status is always sent; the running-status register is absent.

Test Plan:
- Run with CLK_DIV=8, iRST pulsed. Idle: midi_txd=1, ev_ready=1.
- Note on, ch 3, d1=8'h3c, d2=8'h64 -> bytes 93,3C,64.
  - midi_txd low 2 cycles after accept.
  - Each bit 8 cycles; frame length 3*(80+1)-1 cycles.
  - 3 byte_sent pulses, then frame_done and ev_ready high.
- Prog change, d1=8'h85 -> C3,05 (bit7 masked); 2 byte_sent pulses.
- Sysex, d1=8'h0e, d2=8'h12, d3=8'h7f -> F0,7D,00,06,12,7F,F7.
- Iterate over frames mid-frame:
  - iRST asserted during DATA of byte 2 -> midi_txd=1 and ev_ready=1 the next cycle.
  - Next event then starts with a full status byte.
- Two note-ons on ch 0:
  - With MIDI_ENC_RUNNING_STATUS_EN: 90,k,v then k,v only.
  - Without the macro: both frames send 3 bytes.
  - ev_valid held during the first frame causes no second accept until frame_done.
